// File: rtl/proc_sink_pkg.sv
// rtl/proc_sink_pkg.sv - shared defaults and derived widths for the arrayed ring sink
package proc_sink_pkg;

  localparam int DEF_WIDTH  = 2;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_WRAP_W = 8;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/proc_sink_arrayed_ring_if.sv
// rtl/proc_sink_arrayed_ring_if.sv - write-side controls and flattened array view of the ring sink
interface proc_sink_arrayed_ring_if
  import proc_sink_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WRAP_W = DEF_WRAP_W
) ();

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic                   wr_en;
  logic [WIDTH-1:0]       wr_data;
  logic                   freeze;
  logic                   clear;
  logic [WIDTH*DEPTH-1:0] out;
  logic [DEPTH-1:0]       valid;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       count;
  logic                   full;
  logic [WRAP_W-1:0]      wrap_cnt;

  modport master (
    output wr_en, wr_data, freeze, clear,
    input  out, valid, wr_ptr, count, full, wrap_cnt
  );

  modport slave (
    input  wr_en, wr_data, freeze, clear,
    output out, valid, wr_ptr, count, full, wrap_cnt
  );

endinterface

// File: rtl/proc_sink_ring_ptr.sv
// rtl/proc_sink_ring_ptr.sv - modulo-DEPTH write pointer, saturating occupancy and wrap counter
module proc_sink_ring_ptr
  import proc_sink_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WRAP_W = DEF_WRAP_W,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              advance,
  input  logic              clear_all,
  input  logic              clear_keep_wrap,
  output logic [PTR_W-1:0]  ptr_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [WRAP_W-1:0] wrap_cnt_o
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;

  // Wrap is explicit at DEPTH-1 so non-power-of-two depths never reach DEPTH.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wrap_d = wrap_q;
    if (clear_keep_wrap) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (advance) begin
      ptr_d = (ptr_q == LAST_PTR) ? '0 : ptr_q + PTR_W'(1);
      cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + CNT_W'(1);
      if (ptr_q == LAST_PTR) wrap_d = wrap_q + WRAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear_all) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign ptr_o      = ptr_q;
  assign count_o    = cnt_q;
  assign wrap_cnt_o = wrap_q;

endmodule

// File: rtl/proc_sink_arrayed_ring.sv
// rtl/proc_sink_arrayed_ring.sv - round-robin register array sink with freeze, soft clear and flattened output
module proc_sink_arrayed_ring
  import proc_sink_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WRAP_W = DEF_WRAP_W
) (
  input  logic                    clk,
  input  logic                    rst,
  proc_sink_arrayed_ring_if.slave bus
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;
  logic             advance;

  assign advance = bus.wr_en & ~bus.freeze & ~bus.clear & ~rst;

  proc_sink_ring_ptr #(
    .DEPTH  (DEPTH),
    .WRAP_W (WRAP_W)
  ) u_ptr (
    .clk             (clk),
    .advance         (advance),
    .clear_all       (rst),
    .clear_keep_wrap (bus.clear),
    .ptr_o           (ptr),
    .count_o         (count),
    .wrap_cnt_o      (bus.wrap_cnt)
  );

  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    if (bus.clear) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      valid_d = '0;
    end else if (advance) begin
      mem_d[ptr]   = bus.wr_data;
      valid_d[ptr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      valid_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
    end
  end

  // Entry 0 lands in the most significant slice of the flattened bus.
  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign bus.out[(DEPTH-1-g)*WIDTH +: WIDTH] = mem_q[g];
  end

  assign bus.valid  = valid_q;
  assign bus.wr_ptr = ptr;
  assign bus.count  = count;
  assign bus.full   = (count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_proc_sink_arrayed_ring.sv
// tb/tb_proc_sink_arrayed_ring.sv - lockstep bench for DEPTH=4 and DEPTH=3 ring sinks against a queue-free array model
module tb_proc_sink_arrayed_ring;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  proc_sink_arrayed_ring_if #(.WIDTH(2), .DEPTH(4), .WRAP_W(8)) if4 ();
  proc_sink_arrayed_ring_if #(.WIDTH(2), .DEPTH(3), .WRAP_W(2)) if3 ();

  proc_sink_arrayed_ring #(.WIDTH(2), .DEPTH(4), .WRAP_W(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  proc_sink_arrayed_ring #(.WIDTH(2), .DEPTH(3), .WRAP_W(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int depth_of [2] = '{4, 3};
  int wmod_of  [2] = '{256, 4};
  int mmem  [2][4];
  int mval  [2][4];
  int mptr  [2];
  int mcnt  [2];
  int mwrap [2];

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input int k, input bit r, input bit c, input bit f,
                                     input bit w, input int d);
    if (r || c) begin
      for (int i = 0; i < 4; i++) begin
        mmem[k][i] = 0;
        mval[k][i] = 0;
      end
      mptr[k] = 0;
      mcnt[k] = 0;
      if (r) mwrap[k] = 0;
    end else if (!f && w) begin
      mmem[k][mptr[k]] = d;
      mval[k][mptr[k]] = 1;
      mptr[k] = (mptr[k] + 1) % depth_of[k];
      if (mptr[k] == 0) mwrap[k] = (mwrap[k] + 1) % wmod_of[k];
      mcnt[k] = (mcnt[k] + 1 > depth_of[k]) ? depth_of[k] : mcnt[k] + 1;
    end
  endfunction

  task automatic check_model(input int k);
    logic [31:0] e_out;
    logic [31:0] e_val;
    e_out = 0;
    e_val = 0;
    for (int i = 0; i < depth_of[k]; i++) begin
      e_out = (e_out << 2) | 32'(mmem[k][i]);
      if (mval[k][i] != 0) e_val = e_val | (32'd1 << i);
    end
    if (k == 0) begin
      cmp("d4_out",   32'(if4.out),      e_out);
      cmp("d4_valid", 32'(if4.valid),    e_val);
      cmp("d4_ptr",   32'(if4.wr_ptr),   32'(mptr[0]));
      cmp("d4_count", 32'(if4.count),    32'(mcnt[0]));
      cmp("d4_full",  32'(if4.full),     32'(mcnt[0] == 4));
      cmp("d4_wrap",  32'(if4.wrap_cnt), 32'(mwrap[0]));
    end else begin
      cmp("d3_out",   32'(if3.out),      e_out);
      cmp("d3_valid", 32'(if3.valid),    e_val);
      cmp("d3_ptr",   32'(if3.wr_ptr),   32'(mptr[1]));
      cmp("d3_count", 32'(if3.count),    32'(mcnt[1]));
      cmp("d3_full",  32'(if3.full),     32'(mcnt[1] == 3));
      cmp("d3_wrap",  32'(if3.wrap_cnt), 32'(mwrap[1]));
      cmp("d3_ptr_lt_depth", 32'(if3.wr_ptr < 2'd3), 32'd1);
    end
  endtask

  task automatic step(input bit r, input bit c, input bit f, input bit w, input logic [1:0] d);
    rst         = r;
    if4.clear   = c;  if3.clear   = c;
    if4.freeze  = f;  if3.freeze  = f;
    if4.wr_en   = w;  if3.wr_en   = w;
    if4.wr_data = d;  if3.wr_data = d;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      model_step(k, r, c, f, w, int'(d));
      check_model(k);
    end
  endtask

  initial begin
    logic [7:0] snap_out;
    logic [1:0] rd;
    checks = 0;
    errors = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        mmem[k][i] = 0;
        mval[k][i] = 0;
      end
      mptr[k] = 0; mcnt[k] = 0; mwrap[k] = 0;
    end
    rst = 1'b1;
    if4.clear = 1'b0; if4.freeze = 1'b0; if4.wr_en = 1'b0; if4.wr_data = 2'b00;
    if3.clear = 1'b0; if3.freeze = 1'b0; if3.wr_en = 1'b0; if3.wr_data = 2'b00;

    // Reset then idle
    step(1, 0, 0, 0, 2'b00);
    step(0, 0, 0, 0, 2'b00);
    cmp("rst_out",   32'(if4.out),      32'h00);
    cmp("rst_valid", 32'(if4.valid),    32'h0);
    cmp("rst_count", 32'(if4.count),    32'd0);
    cmp("rst_full",  32'(if4.full),     32'd0);
    cmp("rst_ptr",   32'(if4.wr_ptr),   32'd0);
    cmp("rst_wrap",  32'(if4.wrap_cnt), 32'd0);

    // Fill to full
    step(0, 0, 0, 1, 2'b01);
    step(0, 0, 0, 1, 2'b10);
    step(0, 0, 0, 1, 2'b11);
    step(0, 0, 0, 1, 2'b00);
    cmp("fill_out",   32'(if4.out),      32'b01_10_11_00);
    cmp("fill_valid", 32'(if4.valid),    32'hF);
    cmp("fill_full",  32'(if4.full),     32'd1);
    cmp("fill_ptr",   32'(if4.wr_ptr),   32'd0);
    cmp("fill_wrap",  32'(if4.wrap_cnt), 32'd1);

    // Overwrite oldest
    step(0, 0, 0, 1, 2'b11);
    cmp("ovw_out",   32'(if4.out),      32'b11_10_11_00);
    cmp("ovw_count", 32'(if4.count),    32'd4);
    cmp("ovw_ptr",   32'(if4.wr_ptr),   32'd1);
    cmp("ovw_wrap",  32'(if4.wrap_cnt), 32'd1);

    // Freeze drops writes, release lands at current pointer
    snap_out = if4.out;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 2'b10);
      cmp("frz_out", 32'(if4.out),    32'(snap_out));
      cmp("frz_ptr", 32'(if4.wr_ptr), 32'd1);
    end
    step(0, 0, 0, 1, 2'b01);
    cmp("unfrz_out", 32'(if4.out),    32'b11_01_11_00);
    cmp("unfrz_ptr", 32'(if4.wr_ptr), 32'd2);

    // Clear with concurrent write keeps wrap count
    step(1, 0, 0, 0, 2'b00);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 2'(i + 1));
    step(0, 1, 0, 1, 2'b11);
    cmp("clr_out",   32'(if4.out),      32'h00);
    cmp("clr_valid", 32'(if4.valid),    32'h0);
    cmp("clr_count", 32'(if4.count),    32'd0);
    cmp("clr_ptr",   32'(if4.wr_ptr),   32'd0);
    cmp("clr_wrap",  32'(if4.wrap_cnt), 32'd1);

    // Reset with concurrent write zeroes wrap count
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 2'(i));
    step(1, 0, 0, 1, 2'b11);
    cmp("rstw_out",  32'(if4.out),      32'h00);
    cmp("rstw_wrap", 32'(if4.wrap_cnt), 32'd0);

    // DEPTH=3 pointer sequence over 13 writes
    for (int i = 0; i < 13; i++) begin
      step(0, 0, 0, 1, 2'($urandom_range(0, 3)));
      cmp("d3_seq_ptr", 32'(if3.wr_ptr), 32'((i + 1) % 3));
    end
    cmp("d3_final_ptr",  32'(if3.wr_ptr),   32'd1);
    cmp("d3_final_wrap", 32'(if3.wrap_cnt), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      rd = 2'($urandom_range(0, 3));
      step($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
